uart_report_formatter: RTL and testbench



---
 rtl/uart_report_formatter.sv | 185 ++++++++++++++++++
 tb/tb_uart_report_formatter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/uart_report_formatter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_report_formatter
//  Brief    : Formats "V=dddd,L=d\r\n" from a sampled reading/level and feeds
//             it byte-wise to an 8N1 UART transmitter with a stop-bit gap.
//  Revision : 1.0  initial release
// ============================================================================
module uart_report_formatter #(
  parameter int CLK_FREQ   = 40_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int GAP_CYCLES = CLK_FREQ / BAUD_RATE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send,
  input  logic [11:0] value,
  input  logic [1:0]  level,
  input  logic        tx_busy,
  output logic        ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        done
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [3:0]    LAST_IDX = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONV    = 3'd1,
    S_START   = 3'd2,
    S_WAIT_HI = 3'd3,
    S_WAIT_LO = 3'd4,
    S_GAP     = 3'd5,
    S_FIN     = 3'd6
  } state_t;

  state_t      state, state_nx;
  logic [11:0] residual, residual_nx;
  logic [1:0]  lvl, lvl_nx;
  logic [3:0]  d3, d3_nx, d2, d2_nx, d1, d1_nx;
  logic [1:0]  stage, stage_nx;
  logic [3:0]  idx, idx_nx;
  logic [GW-1:0] gap_cnt, gap_cnt_nx;
  logic [7:0]  data_nx;
  logic [9:0]  weight;
  logic [3:0]  idx_inc;

  // Once conversion ends the residual holds d0 in its low nibble.
  function automatic logic [7:0] report_byte(
    input logic [3:0] i,
    input logic [3:0] a, b, c, d,
    input logic [1:0] l
  );
    case (i)
      4'd0:    report_byte = 8'h56;
      4'd1:    report_byte = 8'h3D;
      4'd2:    report_byte = 8'h30 + {4'h0, a};
      4'd3:    report_byte = 8'h30 + {4'h0, b};
      4'd4:    report_byte = 8'h30 + {4'h0, c};
      4'd5:    report_byte = 8'h30 + {4'h0, d};
      4'd6:    report_byte = 8'h2C;
      4'd7:    report_byte = 8'h4C;
      4'd8:    report_byte = 8'h3D;
      4'd9:    report_byte = 8'h30 + {6'h00, l};
      4'd10:   report_byte = 8'h0D;
      default: report_byte = 8'h0A;
    endcase
  endfunction

  always_comb begin
    case (stage)
      2'd0:    weight = 10'd1000;
      2'd1:    weight = 10'd100;
      default: weight = 10'd10;
    endcase
  end

  assign idx_inc = idx + 4'd1;

  always_comb begin
    state_nx    = state;
    residual_nx = residual;
    lvl_nx      = lvl;
    d3_nx       = d3;
    d2_nx       = d2;
    d1_nx       = d1;
    stage_nx    = stage;
    idx_nx      = idx;
    gap_cnt_nx  = gap_cnt;
    data_nx     = tx_data;
    ready       = 1'b0;
    tx_start    = 1'b0;
    done        = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (send) begin
          residual_nx = value;
          lvl_nx      = level;
          d3_nx       = 4'd0;
          d2_nx       = 4'd0;
          d1_nx       = 4'd0;
          stage_nx    = 2'd0;
          idx_nx      = 4'd0;
          state_nx    = S_CONV;
        end
      end
      S_CONV: begin
        if (residual >= {2'b00, weight}) begin
          residual_nx = residual - {2'b00, weight};
          case (stage)
            2'd0:    d3_nx = d3 + 4'd1;
            2'd1:    d2_nx = d2 + 4'd1;
            default: d1_nx = d1 + 4'd1;
          endcase
        end else if (stage == 2'd2) begin
          data_nx  = report_byte(4'd0, d3, d2, d1, residual[3:0], lvl);
          state_nx = S_START;
        end else begin
          stage_nx = stage + 2'd1;
        end
      end
      S_START: begin
        tx_start = 1'b1;
        state_nx = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (tx_busy) state_nx = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!tx_busy) begin
          gap_cnt_nx = GAP_LOAD;
          state_nx   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt != '0) begin
          gap_cnt_nx = gap_cnt - 1'b1;
        end else if (idx == LAST_IDX) begin
          state_nx = S_FIN;
        end else begin
          // Next byte is loaded here so tx_data is already valid in START.
          idx_nx   = idx_inc;
          data_nx  = report_byte(idx_inc, d3, d2, d1, residual[3:0], lvl);
          state_nx = S_START;
        end
      end
      S_FIN: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      residual <= '0;
      lvl      <= '0;
      d3       <= '0;
      d2       <= '0;
      d1       <= '0;
      stage    <= '0;
      idx      <= '0;
      gap_cnt  <= '0;
      tx_data  <= 8'h00;
    end else begin
      state    <= state_nx;
      residual <= residual_nx;
      lvl      <= lvl_nx;
      d3       <= d3_nx;
      d2       <= d2_nx;
      d1       <= d1_nx;
      stage    <= stage_nx;
      idx      <= idx_nx;
      gap_cnt  <= gap_cnt_nx;
      tx_data  <= data_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_report_formatter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_report_formatter
//  Brief    : Scoreboard bench with a busy-stretching transmitter model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_report_formatter;

  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        send = 1'b0;
  logic [11:0] value = '0;
  logic [1:0]  level = '0;
  logic        tx_busy;
  logic        ready, tx_start, done;
  logic [7:0]  tx_data;

  always #5 clk = ~clk;

  uart_report_formatter #(.GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .send(send), .value(value), .level(level),
    .tx_busy(tx_busy), .ready(ready), .tx_start(tx_start),
    .tx_data(tx_data), .done(done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Transmitter: busy rises the cycle after the strobe and lasts busy_len cycles.
  int busy_len = 50;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (busy_cnt > 0)  busy_cnt <= busy_cnt - 1;
    else if (tx_start) busy_cnt <= busy_len;
  end
  assign tx_busy = (busy_cnt != 0);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int strobes = 0, dones = 0, msg_idx = 0, unstable = 0;
  int send_cyc = 0, exp_conv = 0, last_cyc = 0, prev_len = 0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_start) begin
        if (msg_idx == 0) check_val("conv_latency", cyc - send_cyc, exp_conv);
        else              check_val("byte_period", cyc - last_cyc, 2 + prev_len + GAP);
        check_val("strobe_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check_val("tx_byte", tx_data, exp_q.pop_front());
        last_cyc = cyc;
        prev_len = busy_len;
        msg_idx++;
        strobes++;
      end else if (tx_data !== prev_data) begin
        unstable++;
      end
      if (done) dones++;
    end
    prev_data = tx_data;
  end

  task automatic do_send(input int v, input int l);
    int a, b, c, d;
    a = v / 1000; b = (v / 100) % 10; c = (v / 10) % 10; d = v % 10;
    @(negedge clk);
    value = 12'(v); level = 2'(l); send = 1'b1;
    exp_q.push_back(8'h56); exp_q.push_back(8'h3D);
    exp_q.push_back(8'h30 + 8'(a)); exp_q.push_back(8'h30 + 8'(b));
    exp_q.push_back(8'h30 + 8'(c)); exp_q.push_back(8'h30 + 8'(d));
    exp_q.push_back(8'h2C); exp_q.push_back(8'h4C); exp_q.push_back(8'h3D);
    exp_q.push_back(8'h30 + 8'(l)); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    exp_conv = a + b + c + 3;
    msg_idx  = 0;
    send_cyc = cyc + 1;
    @(negedge clk);
    send = 1'b0;
    check_val("ready_low", ready, 0);
  endtask

  task automatic wait_done(input int budget);
    int d0, k;
    d0 = dones; k = 0;
    while (dones == d0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    check_val("ready_after_done", ready, 1);
    repeat (5) @(negedge clk);
    check_val("done_count", dones - d0, 1);
    check_val("bytes_in_msg", msg_idx, 12);
    check_val("queue_empty", exp_q.size(), 0);
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int k;
    k = 0;
    while (msg_idx < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check_val("strobe_reached", msg_idx >= n, 1);
  endtask

  initial begin
    int s0, d0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_val("idle_outputs", {ready, tx_start, tx_data, done}, {1'b1, 1'b0, 8'h00, 1'b0});
    end

    do_send(1234, 2); wait_done(3000);
    do_send(0, 1);    wait_done(3000);
    do_send(4095, 3); wait_done(3000);

    // Second send and input changes while the message is in flight.
    unstable = 0;
    do_send(567, 1);
    repeat (100) @(negedge clk);
    value = 12'd999; level = 2'd0; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    repeat (200) @(negedge clk);
    value = 12'd4000; level = 2'd3;
    wait_done(3000);
    s0 = strobes;
    repeat (300) @(negedge clk);
    check_val("ignored_send", strobes - s0, 0);
    check_val("data_stable", unstable, 0);

    // Abort in WAIT_LO of byte 5.
    do_send(3210, 1);
    wait_strobes(6, 3000);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    s0 = strobes; d0 = dones;
    check_val("ready_after_abort", ready, 1);
    repeat (200) @(negedge clk);
    check_val("abort_no_strobe", strobes - s0, 0);
    check_val("abort_no_done", dones - d0, 0);
    do_send(2048, 0); wait_done(3000);

    // Byte 0 busy stretched to 500 cycles.
    unstable = 0;
    busy_len = 500;
    do_send(89, 3);
    wait_strobes(1, 100);
    #1 busy_len = 50;
    repeat (300) @(negedge clk);
    check_val("stretch_data", tx_data, 8'h56);
    check_val("stretch_strobes", msg_idx, 1);
    wait_done(4000);
    check_val("stretch_stable", unstable, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
